// File: rtl/pid_cfg_sequencer.sv
// Replays a small table of (address, data) writes onto a PID register bus, one
// entry at a time, with ack/timeout supervision and a programmable gap after each ack.
module pid_cfg_sequencer #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int NE  = 8,
    parameter int TMO = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tbl_wen,
    input  logic [$clog2(NE)-1:0] tbl_idx,
    input  logic [AW-1:0]         tbl_addr,
    input  logic [DW-1:0]         tbl_data,
    input  logic [$clog2(NE):0]   cfg_len,
    input  logic [15:0]           cfg_dwell,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [$clog2(NE)-1:0] err_idx,
    output logic                  m_wen,
    output logic [AW-1:0]         m_addr,
    output logic [DW-1:0]         m_wdata,
    input  logic                  m_ack,
    input  logic                  m_err
);

    localparam int IW = $clog2(NE);
    localparam int LW = IW + 1;
    localparam int CW = ($clog2(TMO + 1) > 16) ? $clog2(TMO + 1) : 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DWELL} state_t;

    state_t        state_q;
    logic [AW-1:0] tbl_addr_q [NE];
    logic [DW-1:0] tbl_data_q [NE];
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic [LW-1:0] len_q;
    logic [15:0]   dwell_q;
    logic [CW-1:0] cnt_q;
    logic          abort_pend_q;
    logic          done_q;
    logic          err_q;
    logic [IW-1:0] err_idx_q;
    logic          m_wen_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic          len_ok;
    logic          last_entry;

    assign len_ok     = (cfg_len != '0) && (cfg_len <= LW'(NE));
    assign last_entry = ({1'b0, idx_q} == (len_q - LW'(1)));
    assign idx_d      = idx_q + IW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NE; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
        end else if (tbl_wen && (state_q == IDLE)) begin
            tbl_addr_q[tbl_idx] <= tbl_addr;
            tbl_data_q[tbl_idx] <= tbl_data;
        end
    end

    // m_wen is raised on the edge that enters ISSUE, so the strobe is visible
    // during the ISSUE cycle; the timeout count starts on that same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            abort_pend_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_idx_q    <= '0;
            m_wen_q      <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            m_wen_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    abort_pend_q <= 1'b0;
                    if (start && !abort) begin
                        if (len_ok) begin
                            len_q     <= cfg_len;
                            dwell_q   <= cfg_dwell;
                            err_q     <= 1'b0;
                            err_idx_q <= '0;
                            idx_q     <= '0;
                            m_wen_q   <= 1'b1;
                            m_addr_q  <= tbl_addr_q[0];
                            m_wdata_q <= tbl_data_q[0];
                            cnt_q     <= CW'(TMO);
                            state_q   <= ISSUE;
                        end else begin
                            err_q     <= 1'b1;
                            err_idx_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= cnt_q - CW'(1);
                    state_q <= abort ? IDLE : WAIT;
                end
                WAIT: begin
                    if (abort) abort_pend_q <= 1'b1;
                    if (m_ack) begin
                        if (m_err) begin
                            err_q     <= 1'b1;
                            err_idx_q <= idx_q;
                            state_q   <= IDLE;
                        end else if (last_entry) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if (abort || abort_pend_q) begin
                            state_q <= IDLE;
                        end else if (dwell_q == 16'd0) begin
                            idx_q     <= idx_d;
                            m_wen_q   <= 1'b1;
                            m_addr_q  <= tbl_addr_q[idx_d];
                            m_wdata_q <= tbl_data_q[idx_d];
                            cnt_q     <= CW'(TMO);
                            state_q   <= ISSUE;
                        end else begin
                            cnt_q   <= CW'(dwell_q - 16'd1);
                            state_q <= DWELL;
                        end
                    end else if (cnt_q <= CW'(1)) begin
                        err_q     <= 1'b1;
                        err_idx_q <= idx_q;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DWELL: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        idx_q     <= idx_d;
                        m_wen_q   <= 1'b1;
                        m_addr_q  <= tbl_addr_q[idx_d];
                        m_wdata_q <= tbl_data_q[idx_d];
                        cnt_q     <= CW'(TMO);
                        state_q   <= ISSUE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign err_idx = err_idx_q;
    assign m_wen   = m_wen_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_pid_cfg_sequencer.sv
// Directed bench for pid_cfg_sequencer: table replay, bus errors, timeout, abort,
// mid-run reset and illegal configuration, with cycle-exact latency checks.
module tb_pid_cfg_sequencer;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NE  = 8;
    localparam int TMO = 255;
    localparam int IW  = $clog2(NE);
    localparam int LW  = IW + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          tbl_wen = 1'b0;
    logic [IW-1:0] tbl_idx = '0;
    logic [AW-1:0] tbl_addr = '0;
    logic [DW-1:0] tbl_data = '0;
    logic [LW-1:0] cfg_len = '0;
    logic [15:0]   cfg_dwell = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          m_ack = 1'b0;
    logic          m_err = 1'b0;
    logic          busy, done, err, m_wen;
    logic [IW-1:0] err_idx;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_cyc  = 0;
    int done_cnt = 0;
    logic [AW-1:0] seen_addr [$];
    logic [DW-1:0] seen_data [$];
    int            seen_cyc  [$];

    pid_cfg_sequencer #(.AW(AW), .DW(DW), .NE(NE), .TMO(TMO)) dut (
        .clk(clk), .rstn(rstn), .tbl_wen(tbl_wen), .tbl_idx(tbl_idx),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .cfg_len(cfg_len),
        .cfg_dwell(cfg_dwell), .start(start), .abort(abort), .busy(busy),
        .done(done), .err(err), .err_idx(err_idx), .m_wen(m_wen),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge and log every bus write seen.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (m_wen === 1'b1) begin
            seen_addr.push_back(m_addr);
            seen_data.push_back(m_wdata);
            seen_cyc.push_back(cyc);
            $display("txn %0d: cyc=%0d m_wen addr=0x%08h data=0x%08h",
                     seen_addr.size() - 1, cyc, m_addr, m_wdata);
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wr_tbl(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        tbl_wen = 1'b1; tbl_idx = IW'(i); tbl_addr = a; tbl_data = d;
        step();
        tbl_wen = 1'b0;
    endtask

    task automatic go(input int len, input int dwell);
        cfg_len = LW'(len); cfg_dwell = 16'(dwell); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called in the m_wen cycle: acknowledge in the following (WAIT) cycle.
    task automatic ack(input logic e);
        step();
        m_ack = 1'b1; m_err = e; ack_cyc = cyc;
        step();
        m_ack = 1'b0; m_err = 1'b0;
    endtask

    task automatic wait_new(input int base, input int lim);
        int k = 0;
        while (seen_addr.size() <= base && k < lim) begin
            step();
            k++;
        end
        chk("wen_wait_bound", 64'(seen_addr.size() > base), 64'd1);
    endtask

    initial begin
        int base;
        int dbase;
        int w;
        logic [AW-1:0] ea [4];
        logic [DW-1:0] ed [4];
        ea[0] = 'h10;  ea[1] = 'h14;  ea[2] = 'h18;  ea[3] = 'h0;
        ed[0] = 'h100; ed[1] = 'h200; ed[2] = 'h300; ed[3] = 'h0;

        // Reset state
        steps(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_m_wen", m_wen, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        rstn = 1'b1;
        step();

        // Four-entry run, dwell 2, ack one cycle after each m_wen
        for (int i = 0; i < 4; i++) wr_tbl(i, ea[i], ed[i]);
        base = seen_addr.size(); dbase = done_cnt;
        go(4, 2);
        chk("t1_start_lat", m_wen, 1);
        chk("t1_busy", busy, 1);
        for (int e = 0; e < 4; e++) begin
            if (e > 0) begin
                wait_new(base + e, 20);
                chk("t1_ack_to_wen", 64'(seen_cyc[base + e] - ack_cyc), 64'd3);
            end
            ack(1'b0);
        end
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        step();
        chk("t1_done_oneshot", done, 0);
        chk("t1_wen_count", 64'(seen_addr.size() - base), 64'd4);
        chk("t1_done_count", 64'(done_cnt - dbase), 64'd1);
        chk("t1_err", err, 0);
        for (int e = 0; e < 4; e++) begin
            chk("t1_addr", seen_addr[base + e], ea[e]);
            chk("t1_data", seen_data[base + e], ed[e]);
        end

        // Three-entry run, dwell 0, bus error on entry 1
        base = seen_addr.size(); dbase = done_cnt;
        go(3, 0);
        ack(1'b0);
        chk("t2_wen1_seen", 64'(seen_addr.size() - base), 64'd2);
        chk("t2_dwell0_lat", 64'(seen_cyc[base + 1] - ack_cyc), 64'd1);
        ack(1'b1);
        chk("t2_err", err, 1);
        chk("t2_err_idx", err_idx, 1);
        chk("t2_busy", busy, 0);
        steps(5);
        chk("t2_wen_count", 64'(seen_addr.size() - base), 64'd2);
        chk("t2_no_done", 64'(done_cnt - dbase), 64'd0);

        // Illegal lengths
        base = seen_addr.size();
        go(0, 0);
        chk("t3_len0_err", err, 1);
        chk("t3_len0_err_idx", err_idx, 0);
        chk("t3_len0_busy", busy, 0);
        go(9, 0);
        chk("t3_len9_err", err, 1);
        chk("t3_len9_busy", busy, 0);
        steps(3);
        chk("t3_no_wen", 64'(seen_addr.size() - base), 64'd0);

        // Ack timeout on entry 0, stray ack at cycle 300 after m_wen
        base = seen_addr.size(); dbase = done_cnt;
        go(3, 0);
        w = cyc;
        chk("t4_wen", m_wen, 1);
        chk("t4_err_cleared", err, 0);
        steps(TMO - 1);
        chk("t4_err_before", err, 0);
        chk("t4_busy_before", busy, 1);
        step();
        chk("t4_err_at_tmo", err, 1);
        chk("t4_err_idx", err_idx, 0);
        chk("t4_busy_at_tmo", busy, 0);
        steps(w + 300 - cyc);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        steps(5);
        chk("t4_stray_wen", 64'(seen_addr.size() - base), 64'd1);
        chk("t4_stray_busy", busy, 0);
        chk("t4_stray_err", err, 1);
        chk("t4_stray_done", 64'(done_cnt - dbase), 64'd0);

        // Abort while dwelling after entry 2 of 6
        wr_tbl(4, 'h20, 'h500);
        wr_tbl(5, 'h24, 'h600);
        base = seen_addr.size(); dbase = done_cnt;
        go(6, 4);
        ack(1'b0);
        wait_new(base + 1, 20);
        ack(1'b0);
        wait_new(base + 2, 20);
        ack(1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_done", done, 0);
        chk("t5_abort_err", err, 0);
        steps(10);
        chk("t5_wen_count", 64'(seen_addr.size() - base), 64'd3);
        chk("t5_no_done", 64'(done_cnt - dbase), 64'd0);

        // Abort while waiting: stays busy until the ack arrives
        base = seen_addr.size(); dbase = done_cnt;
        go(2, 0);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_wait_busy", busy, 1);
        steps(3);
        chk("t6_wait_busy_later", busy, 1);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk("t6_idle_after_ack", busy, 0);
        chk("t6_err", err, 0);
        steps(3);
        chk("t6_wen_count", 64'(seen_addr.size() - base), 64'd1);
        chk("t6_no_done", 64'(done_cnt - dbase), 64'd0);

        // Reset pulsed during WAIT
        base = seen_addr.size();
        go(2, 0);
        step();
        rstn = 1'b0;
        #1;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_m_wen", m_wen, 0);
        chk("t7_rst_m_addr", m_addr, 0);
        chk("t7_rst_m_wdata", m_wdata, 0);
        chk("t7_rst_err", err, 0);
        chk("t7_rst_done", done, 0);
        step();
        rstn = 1'b1;
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        steps(4);
        chk("t7_no_wen", 64'(seen_addr.size() - base), 64'd1);
        chk("t7_idle", busy, 0);
        go(2, 0);
        chk("t7_tbl0_wen", m_wen, 1);
        chk("t7_tbl0_addr", m_addr, 0);
        chk("t7_tbl0_data", m_wdata, 0);
        ack(1'b0);
        chk("t7_tbl1_wen", m_wen, 1);
        chk("t7_tbl1_addr", m_addr, 0);
        chk("t7_tbl1_data", m_wdata, 0);
        ack(1'b0);
        chk("t7_done", done, 1);

        // Table write and start while busy are ignored
        wr_tbl(0, 'hA0, 'hAAA);
        base = seen_addr.size();
        go(1, 0);
        tbl_wen = 1'b1; tbl_idx = '0; tbl_addr = 'hBAD; tbl_data = 'hBAD;
        step();
        tbl_wen = 1'b0;
        start = 1'b1; cfg_len = LW'(1); m_ack = 1'b1;
        step();
        start = 1'b0; m_ack = 1'b0;
        chk("t8_done", done, 1);
        steps(3);
        chk("t8_wen_count", 64'(seen_addr.size() - base), 64'd1);
        go(1, 0);
        chk("t8_addr_kept", m_addr, 'hA0);
        chk("t8_data_kept", m_wdata, 'hAAA);
        ack(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pid_cfg_sequencer.md
PID_CFG_SEQUENCER -- requirements
Module: pid_cfg_sequencer

Interface
REQ-001 SHALL have parameters: AW, 32, master address width; DW, 32, master data width; NE, 8, table entries (power of 2); TMO, 255, ack timeout in cycles.
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 tbl_wen  in  1  table write strobe.
REQ-005 tbl_idx  in  $clog2(NE)  table entry index.
REQ-006 tbl_addr / tbl_data  in  AW / DW  entry target address / write data.
REQ-007 cfg_len  in  $clog2(NE)+1  entries per run; 0 and >NE are illegal.
REQ-008 cfg_dwell  in  16  idle cycles inserted after each acked write.
REQ-009 start / abort  in  1 / 1  single-cycle run request / stop request.
REQ-010 busy  out  1  run in progress.
REQ-011 done  out  1  one-cycle pulse at successful run end.
REQ-012 err  out  1  sticky failure flag; err_idx  out  $clog2(NE)  failing entry index.
REQ-013 m_wen  out  1  one-cycle bus write strobe to PID register space.
REQ-014 m_addr / m_wdata  out  AW / DW  bus address / data, held stable from m_wen until response.
REQ-015 m_ack / m_err  in  1 / 1  bus response; m_err valid only with m_ack.

Function
REQ-016 Table SHALL be NE x (AW+DW) registers, written when tbl_wen=1 and busy=0; tbl_wen while busy SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, DWELL.
REQ-018 IDLE: start=1 with legal cfg_len SHALL latch cfg_len and cfg_dwell, clear err and err_idx, set idx=0, go ISSUE; start with illegal cfg_len SHALL set err=1, err_idx=0, and stay IDLE.
REQ-019 ISSUE: SHALL drive m_wen=1 for exactly one cycle with entry[idx], load timeout counter to TMO, go WAIT.
REQ-020 WAIT: m_ack=1 and m_err=0 SHALL go DWELL, or IDLE with done=1 on the next cycle if idx was the last entry.
REQ-021 WAIT: m_ack=1 and m_err=1 SHALL set err=1, err_idx=idx, go IDLE; done SHALL NOT pulse.
REQ-022 WAIT: no ack within TMO cycles after m_wen SHALL set err=1, err_idx=idx, go IDLE; a later stray m_ack SHALL be ignored.
REQ-023 DWELL: SHALL count cfg_dwell cycles, then idx+1, go ISSUE; cfg_dwell=0 SHALL go ISSUE the next cycle.
REQ-024 Latency: start to first m_wen = 1 cycle; ack to next m_wen = cfg_dwell+1 cycles.
REQ-025 abort in ISSUE or DWELL SHALL go IDLE immediately without further m_wen; abort in WAIT SHALL wait for m_ack or timeout first, so no outstanding transaction is orphaned; err and done SHALL be unaffected by abort itself.
REQ-026 start while busy SHALL be ignored; start and abort in the same IDLE cycle SHALL be ignored.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 m_ack in IDLE, ISSUE or DWELL SHALL be ignored.

Reset
REQ-029 rstn=0 SHALL asynchronously force IDLE, busy=0, done=0, err=0, err_idx=0, m_wen=0, m_addr=0, m_wdata=0, counters=0, and all table entries to 0.
REQ-030 Reset deassertion mid-run SHALL leave the block in IDLE with no m_wen issued until a new start.

Verification
REQ-031 Load entries 0..3 = (0x10, 0x100), (0x14, 0x200), (0x18, 0x300), (0x00, 0x0); cfg_len=4, cfg_dwell=2, ack 1 cycle after each m_wen -> exactly 4 m_wen in table order, 3 cycles apart after each ack, done pulses once, err=0.
REQ-032 Run of 3 entries with m_ack+m_err on entry 1 -> 2 m_wen total, err=1, err_idx=1, no done, busy=0.
REQ-033 TMO=255, no m_ack on entry 0 -> err=1, err_idx=0 exactly 255 cycles after m_wen; ack at cycle 300 ignored.
REQ-034 abort while in DWELL after entry 2 of 6 -> no further m_wen, busy=0 next cycle, done=0, err=0; abort in WAIT -> IDLE only after the ack.
REQ-035 rstn pulsed low during WAIT -> outputs and table read back 0 immediately; subsequent m_ack produces no activity.
REQ-036 cfg_len=0 start -> err=1, no m_wen; tbl_wen while busy -> table unchanged on the next run.
